// File: rtl/m_unit_sequencer.sv
// RV32M execution sequencer: single-cycle-registered multiplier and 32-step
// restoring divider behind a small IDLE/MUL/DIV/DONE controller.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an M-op; accepts start when not flushed
// MUL   | latched operands feed the multiplier, product registered on exit
// DIV   | one restoring-divide iteration per edge, counter 0..31
// DONE  | result valid for one cycle, pipeline released
module m_unit_sequencer #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  func3_q, func3_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] div_b_q, div_b_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        in_div_signed;
    logic [31:0] in_a_abs;
    logic [31:0] in_b_abs;
    logic        in_div_zero;
    logic        in_div_ovf;

    logic        mul_a_sgn;
    logic        mul_b_sgn;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    logic [32:0] rem_shift;
    logic        rem_fits;
    logic [31:0] rem_diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operand conditioning at acceptance; func3[0]=0 selects the signed div ops.
    always_comb begin
        in_div_signed = ~func3[0];
        in_a_abs      = (in_div_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
        in_b_abs      = (in_div_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;
        in_div_zero   = (rs2 == 32'd0);
        in_div_ovf    = in_div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    end

    // Sign-extending both operands to 64 bits makes the low 64 product bits
    // correct for every signed/unsigned mix.
    always_comb begin
        mul_a_sgn = (func3_q == 2'b01) || (func3_q == 2'b10);
        mul_b_sgn = (func3_q == 2'b01);
        mul_a     = {{32{mul_a_sgn & a_q[31]}}, a_q};
        mul_b     = {{32{mul_b_sgn & b_q[31]}}, b_q};
        product   = mul_a * mul_b;
    end

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_fits  = (rem_shift >= {1'b0, div_b_q});
        rem_diff  = rem_shift[31:0] - div_b_q;
        rem_next  = rem_fits ? rem_diff : rem_shift[31:0];
        quo_next  = {quo_q[30:0], rem_fits};
        q_fix     = q_neg_q ? (~quo_next + 32'd1) : quo_next;
        r_fix     = r_neg_q ? (~rem_next + 32'd1) : rem_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        a_d      = a_q;
        b_d      = b_q;
        div_b_d  = div_b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    func3_d = func3[1:0];
                    a_d     = rs1;
                    b_d     = rs2;
                    cnt_d   = 6'd0;
                    div_b_d = in_b_abs;
                    quo_d   = in_a_abs;
                    rem_d   = 32'd0;
                    q_neg_d = in_div_signed && (rs1[31] ^ rs2[31]);
                    r_neg_d = in_div_signed && rs1[31];
                    if (!func3[2]) begin
                        state_d = S_MUL;
                    end else if (in_div_zero) begin
                        result_d = func3[1] ? rs1 : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else if (in_div_ovf) begin
                        result_d = func3[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (func3_q == 2'b00) ? product[31:0] : product[63:32];
                state_d  = S_DONE;
            end
            S_DIV: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    result_d = func3_q[1] ? r_fix : q_fix;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted op must not disturb the last delivered result.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = 6'd0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            func3_q  <= 2'b00;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            div_b_q  <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            div_b_q  <= div_b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall  = (start && (state_q == S_IDLE) && !flush) ||
                    (state_q == S_MUL) || (state_q == S_DIV);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_m_unit_sequencer.sv
// Scoreboard bench for m_unit_sequencer: directed M-ops with hand-computed
// results and completion cycles, plus flush, reset and start-during-DONE cases.
module tb_m_unit_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    m_unit_sequencer #(.DIV_CYCLES(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          at;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } chk_t;

    exp_t sb[$];
    chk_t chkq[$];
    int   checks = 0;
    int   errors = 0;
    exp_t e;
    chk_t c;

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            checks++;
            if (c.act !== c.req) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", c.name, c.act, c.req);
            end
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done(result=%h) required=no_done", result);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s_result actual=%h required=%h", e.name, result, e.res);
                end
                if (cyc != e.at) begin
                    errors++;
                    $display("FAIL %s_latency actual=cycle%0d required=cycle%0d", e.name, cyc, e.at);
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        chk_t t;
        t.name = n;
        t.act  = act;
        t.req  = req;
        chkq.push_back(t);
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic issue(input string n, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat,
                         input bit track);
        exp_t t;
        start = 1'b1;
        func3 = f;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            t.name = n;
            t.res  = res;
            t.at   = cyc + lat - 1;
            sb.push_back(t);
        end
    endtask

    task automatic wait_idle(input string n);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy || done) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) check({n, "_timeout"}, 32'(k), 32'd0);
    endtask

    task automatic run(input string n, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
        issue(n, f, a, b, res, lat, 1'b1);
        wait_idle(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   n_stall;
        int   n;
        exp_t t;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_stall",  {31'd0, stall}, 32'd0);
        check("rst_result", result,         32'd0);

        // MUL accepted on the first edge after release; stall for 2 cycles
        rst_n   = 1'b1;
        n_stall = 0;
        start = 1'b1; func3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
        @(negedge clk);
        n_stall += int'(stall);
        @(posedge clk);
        #1;
        start = 1'b0;
        t.name = "mul"; t.res = 32'hFFFF_FFEB; t.at = cyc + 1;
        sb.push_back(t);
        repeat (4) begin
            @(negedge clk);
            n_stall += int'(stall);
        end
        check("mul_stall_cycles", 32'(n_stall), 32'd2);
        @(posedge clk);
        #1;
        wait_idle("mul");

        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        run("div",     3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        run("rem",     3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        run("divu",    3'b101, 32'd100, 32'd7, 32'd14, 33);
        run("remu",    3'b111, 32'd100, 32'd7, 32'd2, 33);
        run("divu_big",3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);

        run("divu_by0", 3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_by0",  3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run("divu_nov", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run("remu_nov", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; func3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
        #1;
        check("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // flush at DIV iteration 10, then a fresh DIV one cycle later
        issue("div_flush", 3'b100, 32'd100, 32'd7, 32'd0, 33, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",  {31'd0, busy},  32'd0);
        check("flush_done",  {31'd0, done},  32'd0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        run("div_after_flush", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("rem_after_flush", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        // async reset mid-DIV: immediate clear, no done afterwards
        issue("div_rst", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'd0, 33, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   {31'd0, busy},  32'd0);
        check("arst_done",   {31'd0, done},  32'd0);
        check("arst_stall",  {31'd0, stall}, 32'd0);
        check("arst_result", result,         32'd0);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_after_busy", {31'd0, busy}, 32'd0);

        // start held through MUL/DONE: second op taken only once IDLE again
        start = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clk);
        #1;
        n = cyc;
        t.name = "b2b_first";  t.res = 32'd15; t.at = n + 1;
        sb.push_back(t);
        rs1 = 32'd6; rs2 = 32'd7;
        t.name = "b2b_second"; t.res = 32'd42; t.at = n + 4;
        sb.push_back(t);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("b2b");

        run("divu_seq", 3'b101, 32'd1000, 32'd10, 32'd100, 33);
        run("remu_seq", 3'b111, 32'd1000, 32'd10, 32'd0, 33);
        run("mul_seq",  3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
